systolic_array_ctrl: RTL
========================

# systolic_array_ctrl

Sequencer for the 5x5 output-stationary systolic array. Holds one 5x5 A operand and one 5x5 B operand in internal buffers. On `start` it clears every PE and streams both operands into the array with the diagonal skew the array needs. It then waits for the wavefront to drain and steps a one-hot read strobe across all 25 PEs so downstream logic can collect the results.

## Interface
- `N`, 32, operand word width
- `DIM`, 5, array edge length; lane count per side
- `M`, 25, PE count (DIM*DIM); width of PE control vectors
- `clk` input 1: single clock, rising edge
- `clr` input 1: synchronous, active-high reset; one clock, synchronous active-high reset
- `ld_en` input 1: operand buffer write strobe
- `ld_sel` input 1: 0 = A buffer, 1 = B buffer
- `ld_addr` input 5: row-major index r*DIM+c, 0..24; values 25..31 ignored
- `ld_data` input N: word to store
- `start` input 1: begin one matrix pass
- `A0`..`A4` output N each: row lanes into the array's left edge
- `B0`..`B4` output N each: column lanes into the array's top edge
- `pe_clr` output M: per-PE accumulator clear
- `pe_write` output M: per-PE accumulate enable
- `pe_read` output M: per-PE result read strobe, one-hot
- `res_valid` output 1: a read strobe is active this cycle
- `res_idx` output 5: PE index being read, row-major
- `busy` output 1: pass in progress
- `done` output 1: one-cycle end-of-pass pulse

## Operation
- The A buffer stores A[r][c] at `ld_addr` r*5+c. The B buffer stores B[k][c] at k*5+c.
- Loads are accepted only in IDLE. `ld_en` is ignored in every other state.
- Buffers are not affected by `clr`; their contents persist across passes.
- All outputs are registered.
- State machine:
  - IDLE: wait for `start`. `start` high goes to CLEAR.
  - CLEAR: 1 cycle. `pe_clr` = all ones.
  - FEED: 9 cycles (2*DIM-1), feed counter f = 0..8.
  - DRAIN: 5 cycles (DIM).
  - READ: 25 cycles, read counter r = 0..24.
  - DONE: 1 cycle, then IDLE.
- Lane skew in FEED:
  - `Ai` = A[i][f-i] when 0 <= f-i <= 4, else 0.
  - `Bj` = B[f-j][j] when 0 <= f-j <= 4, else 0.
- `pe_write` = all ones in FEED and DRAIN; 0 otherwise.
- READ: `pe_read` = 1<<r, `res_valid` = 1, `res_idx` = r.
- `busy` = 1 in CLEAR, FEED, DRAIN and READ.
- `done` = 1 only in DONE; `busy` = 0 in DONE.
- `start` outside IDLE is ignored and is not queued.

## Timing
- Reset values (cycle after `clr` sampled high):
  - state IDLE
  - all lanes 0
  - `pe_clr` = all ones, so the array is cleared with the controller
  - `pe_write`, `pe_read`, `res_valid`, `res_idx`, `busy`, `done` = 0
- In IDLE after reset, `pe_clr` = 0.
- `clr` has priority over every other input. Asserted mid-pass, it aborts the pass with no `done` and takes effect the next cycle.
- `start` sampled in IDLE at edge t gives:
  - CLEAR in cycle t+1
  - FEED in cycles t+2..t+10
  - DRAIN in cycles t+11..t+15
  - READ in cycles t+16..t+40
  - `done` in cycle t+41
  - IDLE in cycle t+42
- Latency from `start` to `done` is 41 cycles.
- `start` held high through DONE starts the next pass at t+42, i.e. CLEAR in cycle t+43.
- `ld_en` in the same IDLE cycle as `start` is accepted, and the written word is used by that pass.
- Last operand pair A[4][4]/B[4][4] is on the lanes at f = 8. It reaches PE(4,4) by DRAIN cycle 3; the remaining DRAIN cycles are margin.

## Test plan
- Load A[r][c]=r*5+c+1 and B = identity, pulse `start`. Check:
  - lanes at f = 0: A0=1, B0=1, all other lanes 0
  - at f = 4: A4=21, A0=5
  - at f = 8: only A4=25 and B4=1 are nonzero
  - `done` exactly 41 cycles after `start`
- READ sweep: `pe_read` walks 0x0000001 to 0x1000000, `res_idx` 0..24, `res_valid` high for exactly 25 cycles, `busy` low in the `done` cycle.
- Assert `clr` in feed cycle f = 3. Next cycle: IDLE, all lanes 0, `pe_clr` all ones, `busy` 0. No `done` follows. Buffers keep their loaded values, verified by a second pass giving identical lane traces.
- Pulse `start` and write `ld_en` (A buffer, addr 0, data 0xFFFFFFFF) during DRAIN. Both are ignored: the next pass still shows A0=1 at f = 0 and the timeline is unchanged.
- Hold `start` high continuously. Passes repeat with CLEAR in cycle 43 of each period, and a single `done` pulse every 42 cycles.
- Write to `ld_addr` = 27. No buffer word changes.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a 5x5 output-stationary systolic array: buffers A/B, feeds skewed lanes, sweeps PE reads.
// Start to done is 41 cycles; all outputs registered; loads and start are ignored outside IDLE.
module systolic_array_ctrl #(
  parameter int N   = 32,
  parameter int DIM = 5,
  parameter int M   = 25
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld_en,
  input  logic         ld_sel,
  input  logic [4:0]   ld_addr,
  input  logic [N-1:0] ld_data,
  input  logic         start,
  output logic [N-1:0] A0,
  output logic [N-1:0] A1,
  output logic [N-1:0] A2,
  output logic [N-1:0] A3,
  output logic [N-1:0] A4,
  output logic [N-1:0] B0,
  output logic [N-1:0] B1,
  output logic [N-1:0] B2,
  output logic [N-1:0] B3,
  output logic [N-1:0] B4,
  output logic [M-1:0] pe_clr,
  output logic [M-1:0] pe_write,
  output logic [M-1:0] pe_read,
  output logic         res_valid,
  output logic [4:0]   res_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READ, S_DONE
  } state_t;

  state_t       state;
  logic [4:0]   cnt;
  logic [N-1:0] a_buf  [M];
  logic [N-1:0] b_buf  [M];
  logic [N-1:0] a_lane [DIM];
  logic [N-1:0] b_lane [DIM];

  // Row lane i carries A[i][f-i]; column lane j carries B[f-j][j].
  function automatic logic [N-1:0] a_skew(input int i, input int f);
    int k;
    k = f - i;
    if (k >= 0 && k < DIM) return a_buf[5'(i * DIM + k)];
    return '0;
  endfunction

  function automatic logic [N-1:0] b_skew(input int j, input int f);
    int k;
    k = f - j;
    if (k >= 0 && k < DIM) return b_buf[5'(k * DIM + j)];
    return '0;
  endfunction

  // Operand buffers survive clr so a pass can be rerun without reloading.
  always_ff @(posedge clk) begin
    if (!clr && ld_en && state == S_IDLE && ld_addr < 5'(M)) begin
      if (ld_sel) b_buf[ld_addr] <= ld_data;
      else        a_buf[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pe_clr    <= '1;
      pe_write  <= '0;
      pe_read   <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        a_lane[i] <= '0;
        b_lane[i] <= '0;
      end
    end else begin
      pe_clr    <= '0;
      pe_write  <= '0;
      pe_read   <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        a_lane[i] <= '0;
        b_lane[i] <= '0;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_CLEAR;
            pe_clr <= '1;
            busy   <= 1'b1;
          end
        end
        S_CLEAR: begin
          state    <= S_FEED;
          cnt      <= '0;
          pe_write <= '1;
          busy     <= 1'b1;
          for (int i = 0; i < DIM; i++) begin
            a_lane[i] <= a_skew(i, 0);
            b_lane[i] <= b_skew(i, 0);
          end
        end
        S_FEED: begin
          pe_write <= '1;
          busy     <= 1'b1;
          if (cnt < 5'(2 * DIM - 2)) begin
            cnt <= cnt + 5'd1;
            for (int i = 0; i < DIM; i++) begin
              a_lane[i] <= a_skew(i, int'(cnt) + 1);
              b_lane[i] <= b_skew(i, int'(cnt) + 1);
            end
          end else begin
            state <= S_DRAIN;
            cnt   <= '0;
          end
        end
        S_DRAIN: begin
          busy <= 1'b1;
          if (cnt < 5'(DIM - 1)) begin
            cnt      <= cnt + 5'd1;
            pe_write <= '1;
          end else begin
            state     <= S_READ;
            cnt       <= '0;
            pe_read   <= M'(1);
            res_valid <= 1'b1;
            res_idx   <= '0;
          end
        end
        S_READ: begin
          if (cnt < 5'(M - 1)) begin
            cnt       <= cnt + 5'd1;
            pe_read   <= M'(1) << (cnt + 5'd1);
            res_valid <= 1'b1;
            res_idx   <= cnt + 5'd1;
            busy      <= 1'b1;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign A0 = a_lane[0];
  assign A1 = a_lane[1];
  assign A2 = a_lane[2];
  assign A3 = a_lane[3];
  assign A4 = a_lane[4];
  assign B0 = b_lane[0];
  assign B1 = b_lane[1];
  assign B2 = b_lane[2];
  assign B3 = b_lane[3];
  assign B4 = b_lane[4];

endmodule
